// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared by the two byte-stream requesters, the FIFO write port
// and the arbiter status outputs.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  last0;
    logic                  ack0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last1;
    logic                  ack1;
    logic                  wfull;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            gnt;
    logic                  busy;
    logic                  abort;

    modport master (
        output req0, data0, last0, req1, data1, last1, wfull,
        input  ack0, ack1, winc, wdata, gnt, busy, abort
    );

    modport slave (
        input  req0, data0, last0, req1, data1, last1, wfull,
        output ack0, ack1, winc, wdata, gnt, busy, abort
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter sharing one async-FIFO write port between
// two requesters; closes frames that stall too long or exceed MAX_FRAME words.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_FRAME  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              i_wclk,
    input  logic              i_wrst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t          r_state, w_state_next;
    logic            r_ptr, w_ptr_next;
    logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [IW-1:0]   r_idle, w_idle_next, w_idle_inc;
    logic [1:0]      r_gnt;
    logic            r_busy;
    logic            r_abort, w_abort_next;
    logic            w_close;

    logic [1:0]            w_req;
    logic [1:0]            w_last;
    logic [DATA_WIDTH-1:0] w_data [2];
    logic                  w_sel;
    logic                  w_accept;
    logic [1:0]            w_ack;

    assign w_req     = {bus.req1, bus.req0};
    assign w_last    = {bus.last1, bus.last0};
    assign w_data[0] = bus.data0;
    assign w_data[1] = bus.data1;

    assign w_sel      = (r_state == GRANT1);
    assign w_accept   = (r_state != IDLE) & w_req[w_sel] & ~bus.wfull;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_idle_inc = r_idle + 1'b1;

    // Only the owner of the current frame can ever see an ack.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign w_ack[gi] = w_accept & (w_sel == 1'(gi));
        end
    endgenerate

    assign bus.ack0  = w_ack[0];
    assign bus.ack1  = w_ack[1];
    assign bus.winc  = w_accept;
    assign bus.wdata = w_accept ? w_data[w_sel] : '0;
    assign bus.gnt   = r_gnt;
    assign bus.busy  = r_busy;
    assign bus.abort = r_abort;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_idle_next  = r_idle;
        w_abort_next = 1'b0;
        w_close      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next  = '0;
                w_idle_next = '0;
                if (w_req[0] & w_req[1])
                    w_state_next = r_ptr ? GRANT1 : GRANT0;
                else if (w_req[0])
                    w_state_next = GRANT0;
                else if (w_req[1])
                    w_state_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                // A stalled-by-wfull word still counts as activity, never as idle.
                if (w_req[w_sel]) begin
                    w_idle_next = '0;
                    if (w_accept) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_last[w_sel]) begin
                            w_close = 1'b1;
                        end else if (w_cnt_inc == CW'(MAX_FRAME)) begin
                            w_close      = 1'b1;
                            w_abort_next = 1'b1;
                        end
                    end
                end else begin
                    w_idle_next = w_idle_inc;
                    if (w_idle_inc == IW'(TIMEOUT)) begin
                        w_close      = 1'b1;
                        w_abort_next = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_close) begin
            w_state_next = IDLE;
            w_ptr_next   = ~w_sel;
            w_cnt_next   = '0;
            w_idle_next  = '0;
        end
    end

    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_idle  <= w_idle_next;
            r_gnt   <= {w_state_next == GRANT1, w_state_next == GRANT0};
            r_busy  <= (w_state_next != IDLE);
            r_abort <= w_abort_next;
        end
    end
endmodule
